// File: rtl/load_extend_if.sv
// Bus bundle between the pipeline, the data memory and the load/extend controller.
// The controller takes the slave view; the surrounding pipeline/memory takes the master view.
interface load_extend_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_misalign;

  modport slave (
    input  ld_valid, ld_addr, ld_size, ld_unsigned,
    input  mem_gnt, mem_rvalid, mem_rdata, res_ready,
    output ld_ready, mem_req, mem_addr, res_valid, res_data, res_misalign
  );

  modport master (
    output ld_valid, ld_addr, ld_size, ld_unsigned,
    output mem_gnt, mem_rvalid, mem_rdata, res_ready,
    input  ld_ready, mem_req, mem_addr, res_valid, res_data, res_misalign
  );
endinterface

// File: rtl/load_extend_ctrl.sv
// Single-outstanding load controller: issues a word read, then selects and sign/zero-extends
// the addressed byte or halfword. Misaligned or illegal-size loads return an error result without touching memory.
module load_extend_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  load_extend_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_data;
  logic        r_misalign;
  logic        w_ld_ready;
  logic        w_accept;
  logic        w_misalign_in;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lo[0];
      2'd2:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] lo,
                                         input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    res = uns ? {24'h0, b} : 32'(b);
      2'd1:    res = uns ? {16'h0, h} : 32'(h);
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_misalign_in = misaligned(bus.ld_size, bus.ld_addr[1:0]);
  assign w_accept      = bus.ld_valid && w_ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_misalign <= w_misalign_in;
    end
  end

  // Datapath registers carry no reset; every output they feed is masked by state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr     <= bus.ld_addr;
      r_size     <= bus.ld_size;
      r_unsigned <= bus.ld_unsigned;
      r_data     <= 32'h0;
    end else if (r_state == WAIT && bus.mem_rvalid) begin
      r_data <= extend(bus.mem_rdata, r_addr[1:0], r_size, r_unsigned);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ld_ready       = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_addr     = 32'h0;
    bus.res_valid    = 1'b0;
    bus.res_data     = 32'h0;
    bus.res_misalign = 1'b0;
    case (r_state)
      IDLE: begin
        w_ld_ready = rst_n;
        if (w_accept) w_state_nxt = w_misalign_in ? RESP : REQ;
      end
      REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_addr[31:2], 2'b00};
        if (bus.mem_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) w_state_nxt = RESP;
      end
      RESP: begin
        bus.res_valid    = 1'b1;
        bus.res_data     = r_misalign ? 32'h0 : r_data;
        bus.res_misalign = r_misalign;
        if (bus.res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ld_ready = w_ld_ready;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Scoreboard bench for load_extend_ctrl: directed corner loads followed by randomized loads
// against a reference model, with a reactive memory model and random result back-pressure.
module tb_load_extend_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    int          gd;
    int          rdl;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_extend_if ifc ();
  load_extend_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          outstanding = 0;
  int          n_memreq = 0;
  int          rdy_mode = 1;
  bit          spur_en = 0;
  logic [32:0] sq[$];
  mem_txn_t    mq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: returns {misalign, data}
  function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] sz,
                                        input logic u, input logic [31:0] rd);
    int          nb;
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00))
      return {1'b1, 32'h0};
    nb   = 1 << sz;
    v    = rd >> (8 * a[1:0]);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = v & mask;
    if (!u && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    return {1'b0, v};
  endfunction

  // kind: 0 = expected from model, 1 = explicit expected, 2 = aborted (nothing expected)
  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] rd, input int gd, input int rdl,
                       input int kind, input logic [32:0] exp, output int acc);
    mem_txn_t    t;
    logic [32:0] m;
    int          w;
    acc = -1;
    @(negedge clk);
    ifc.ld_valid    = 1'b1;
    ifc.ld_addr     = a;
    ifc.ld_size     = sz;
    ifc.ld_unsigned = u;
    w = 0;
    while (!ifc.ld_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!ifc.ld_ready) begin
      fail("ld_ready_timeout");
      ifc.ld_valid = 1'b0;
      return;
    end
    m = model(a, sz, u, rd);
    if (!m[32]) begin
      t.addr = {a[31:2], 2'b00};
      t.rd   = rd;
      t.gd   = gd;
      t.rdl  = rdl;
      mq.push_back(t);
    end
    if (kind == 0) sq.push_back(m);
    else if (kind == 1) sq.push_back(exp);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    outstanding++;
    ifc.ld_valid    = 1'b0;
    ifc.ld_addr     = $urandom;
    ifc.ld_size     = 2'($urandom_range(0, 3));
    ifc.ld_unsigned = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((outstanding != 0 || sq.size() != 0 || mq.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (outstanding != 0 || sq.size() != 0 || mq.size() != 0) fail("drain_timeout");
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ifc.res_ready = ($urandom_range(0, 3) != 0);
      1:       ifc.res_ready = 1'b1;
      default: ifc.res_ready = 1'b0;
    endcase
  end

  initial begin : mem_model
    mem_txn_t t;
    ifc.mem_gnt    = 1'b0;
    ifc.mem_rvalid = 1'b0;
    ifc.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.mem_req) begin
        ifc.mem_rvalid = 1'b0;
        if (mq.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          t = mq.pop_front();
          chk("mem_addr", ifc.mem_addr, t.addr);
          for (int i = 0; i < t.gd; i++) begin
            @(negedge clk);
            chk("mem_req_hold", {ifc.mem_req, ifc.mem_addr}, {1'b1, t.addr});
          end
          ifc.mem_gnt = 1'b1;
          @(negedge clk);
          ifc.mem_gnt = 1'b0;
          if (rst_n) chk("mem_req_drop", ifc.mem_req, 1'b0);
          for (int i = 0; i < t.rdl; i++) @(negedge clk);
          ifc.mem_rdata  = t.rd;
          ifc.mem_rvalid = 1'b1;
          @(negedge clk);
          ifc.mem_rvalid = 1'b0;
          ifc.mem_rdata  = $urandom;
        end
      end else begin
        ifc.mem_rvalid = spur_en && ($urandom_range(0, 5) == 0);
        ifc.mem_rdata  = $urandom;
      end
    end
  end

  initial begin : monitor
    logic        hold;
    logic [32:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (ifc.mem_req) n_memreq++;
        chk("ld_ready", ifc.ld_ready, (outstanding == 0));
        if (hold) chk("res_hold", {ifc.res_valid, ifc.res_misalign, ifc.res_data}, {1'b1, held});
        if (!ifc.res_valid) chk("res_idle_zero", {ifc.res_misalign, ifc.res_data}, 33'h0);
        if (ifc.res_valid && !ifc.res_ready) begin
          hold = 1'b1;
          held = {ifc.res_misalign, ifc.res_data};
        end else begin
          hold = 1'b0;
        end
        if (ifc.res_valid && ifc.res_ready) begin
          if (sq.size() == 0) fail("unexpected_result");
          else chk("result", {ifc.res_misalign, ifc.res_data}, sq.pop_front());
          @(posedge clk);
          if (outstanding > 0) outstanding--;
        end
      end
    end
  end

  initial begin : main
    int          a1;
    int          a2;
    int          n;
    int          n0;
    logic [31:0] ad;
    logic [1:0]  sz;
    ifc.ld_valid    = 1'b0;
    ifc.ld_addr     = 32'h0;
    ifc.ld_size     = 2'd0;
    ifc.ld_unsigned = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {ifc.ld_ready, ifc.mem_req, ifc.res_valid, ifc.res_misalign}, 4'b0);
    chk("reset_data", {ifc.mem_addr, ifc.res_data}, 64'h0);
    rst_n = 1'b1;
    #1 chk("ld_ready_after_reset", ifc.ld_ready, 1'b1);

    // LB sign-extend, minimum latency
    issue(32'h1003, 2'd0, 1'b0, 32'h80FF_1234, 0, 0, 1, {1'b0, 32'hFFFF_FF80}, a1);
    n = 0;
    while (!ifc.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("min_latency", n, 3);
    wait_idle();

    issue(32'h2002, 2'd1, 1'b1, 32'hBEEF_0000, 1, 2, 1, {1'b0, 32'h0000_BEEF}, a1);
    issue(32'h2002, 2'd1, 1'b0, 32'hBEEF_0000, 0, 1, 1, {1'b0, 32'hFFFF_BEEF}, a1);
    wait_idle();

    // Misaligned word never reaches memory
    n0 = n_memreq;
    issue(32'h3001, 2'd2, 1'b0, 32'h1111_2222, 0, 0, 1, {1'b1, 32'h0}, a1);
    wait_idle();
    chk("misalign_no_mem_req", n_memreq, n0);

    // Slow grant and result back-pressure
    rdy_mode = 2;
    issue(32'h4000, 2'd2, 1'b1, 32'hCAFE_F00D, 3, 1, 1, {1'b0, 32'hCAFE_F00D}, a1);
    n = 0;
    while (!ifc.res_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("held_result_valid", ifc.res_valid, 1'b1);
    repeat (4) @(negedge clk);
    rdy_mode = 1;
    wait_idle();

    // Reset while waiting for read data; the late rvalid must be ignored
    issue(32'h5004, 2'd2, 1'b0, 32'h1234_5678, 0, 5, 2, 33'h0, a1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    outstanding = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ld_ready_after_abort", ifc.ld_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_result_after_abort", ifc.res_valid, 1'b0);
    end

    // Back-to-back with zero-wait memory
    issue(32'h10, 2'd2, 1'b0, 32'h8765_4321, 0, 0, 1, {1'b0, 32'h8765_4321}, a1);
    issue(32'h11, 2'd0, 1'b0, 32'h0000_9A00, 0, 0, 1, {1'b0, 32'hFFFF_FF9A}, a2);
    chk("b2b_accept_gap", a2 - a1, 4);
    wait_idle();

    // Randomized traffic
    spur_en  = 1;
    rdy_mode = 0;
    for (int k = 0; k < 150; k++) begin
      ad = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      issue(ad, sz, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), 0, 33'h0, a1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    rdy_mode = 1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
